// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, word type and shifter modes for mips_alu.
package alu_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_mode_t;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SUBU = 6'b100011;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_NOR  = 6'b100111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_SLTU = 6'b101011;
    localparam logic [5:0] ALU_SLLV = 6'b000100;
    localparam logic [5:0] ALU_SRLV = 6'b000110;
    localparam logic [5:0] ALU_SRAV = 6'b000111;
    localparam logic [5:0] ALU_LUI  = 6'b001111;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: 32-bit log-stage barrel shifter with left, logical-right and arithmetic-right modes.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [31:0] value,
    input  logic [4:0]  amount,
    input  sh_mode_t    mode,
    output logic [31:0] shifted
);
    word_t stage [0:5];
    logic  fill;
    assign fill = (mode == SH_RA) ? value[31] : 1'b0;
    assign stage[0] = value;
    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int N = 1 << i;
        assign stage[i+1] = !amount[i] ? stage[i] :
                            (mode == SH_LL) ? {stage[i][31-N:0], {N{1'b0}}} :
                            {{N{fill}}, stage[i][31:N]};
    end
    assign shifted = stage[5];
endmodule

// File: rtl/mips_alu.sv
// mips_alu: MIPS funct-encoded ALU with one registered output stage.
// Add/sub wrap modulo 2^32; overflow is flagged only for signed ADD and SUB.
module mips_alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  alucont,
    output logic [31:0] result,
    output logic        overflow
);
    word_t    sum, diff, sh_out, next_result;
    logic     add_ov, sub_ov, next_overflow;
    sh_mode_t sh_mode;
    assign sum    = a + b;
    assign diff   = a - b;
    assign add_ov = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ov = (a[31] != b[31]) && (diff[31] != a[31]);
    assign sh_mode = (alucont == ALU_SLLV) ? SH_LL :
                     (alucont == ALU_SRAV) ? SH_RA : SH_RL;
    alu_shifter u_shifter (
        .value   (b),
        .amount  (a[4:0]),
        .mode    (sh_mode),
        .shifted (sh_out)
    );
    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        case (alucont)
            ALU_ADD:  begin next_result = sum;  next_overflow = add_ov; end
            ALU_ADDU: next_result = sum;
            ALU_SUB:  begin next_result = diff; next_overflow = sub_ov; end
            ALU_SUBU: next_result = diff;
            ALU_AND:  next_result = a & b;
            ALU_OR:   next_result = a | b;
            ALU_XOR:  next_result = a ^ b;
            ALU_NOR:  next_result = ~(a | b);
            ALU_SLT:  next_result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: next_result = {31'b0, a < b};
            ALU_SLLV, ALU_SRLV, ALU_SRAV: next_result = sh_out;
            ALU_LUI:  next_result = {b[15:0], 16'h0000};
            default:  next_result = '0;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            result   <= next_result;
            overflow <= next_overflow;
        end
    end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed self-checking bench for mips_alu with hand-computed expectations.
module tb_mips_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [5:0]  alucont;
    logic [31:0] result;
    logic        overflow;
    int total = 0;
    int bad = 0;

    mips_alu dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .alucont  (alucont),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] er, input logic eo);
        total++;
        assert (result === er && overflow === eo) else begin
            bad++;
            $error("FAIL %s: got result=%h ov=%b, expected result=%h ov=%b", tag, result, overflow, er, eo);
        end
    endtask

    task automatic op(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
        alucont = c;
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a = '0;
        b = '0;
        alucont = 6'b100111;
        #12;
        chk("reset_state", 32'h0, 1'b0);
        reset = 1'b0;
        op(6'b100000, 32'h7FFFFFFF, 32'h00000001); chk("add_pos_ovf", 32'h80000000, 1'b1);
        op(6'b100001, 32'h7FFFFFFF, 32'h00000001); chk("addu_no_ovf", 32'h80000000, 1'b0);
        op(6'b100000, 32'h80000000, 32'h80000000); chk("add_neg_ovf", 32'h00000000, 1'b1);
        op(6'b100000, 32'h00000005, 32'h00000003); chk("add_plain", 32'h00000008, 1'b0);
        op(6'b100010, 32'h80000000, 32'h00000001); chk("sub_ovf", 32'h7FFFFFFF, 1'b1);
        op(6'b100011, 32'h80000000, 32'h00000001); chk("subu_no_ovf", 32'h7FFFFFFF, 1'b0);
        op(6'b100010, 32'h7FFFFFFF, 32'hFFFFFFFF); chk("sub_ovf_pos", 32'h80000000, 1'b1);
        op(6'b100010, 32'h00000003, 32'h00000005); chk("sub_plain", 32'hFFFFFFFE, 1'b0);
        op(6'b101010, 32'h80000000, 32'h00000001); chk("slt_ovf_case", 32'h00000001, 1'b0);
        op(6'b101011, 32'h00000001, 32'hFFFFFFFF); chk("sltu", 32'h00000001, 1'b0);
        op(6'b101010, 32'h00000001, 32'hFFFFFFFF); chk("slt_false", 32'h00000000, 1'b0);
        op(6'b101011, 32'hFFFFFFFF, 32'h00000001); chk("sltu_false", 32'h00000000, 1'b0);
        op(6'b100100, 32'hF0F0F0F0, 32'hFF00FF00); chk("and", 32'hF000F000, 1'b0);
        op(6'b100101, 32'hF0F0F0F0, 32'hFF00FF00); chk("or", 32'hFFF0FFF0, 1'b0);
        op(6'b100110, 32'hF0F0F0F0, 32'hFF00FF00); chk("xor", 32'h0FF00FF0, 1'b0);
        op(6'b000111, 32'h00000004, 32'hF0000000); chk("srav", 32'hFF000000, 1'b0);
        op(6'b000110, 32'h00000004, 32'hF0000000); chk("srlv", 32'h0F000000, 1'b0);
        op(6'b000100, 32'h0000001F, 32'h00000001); chk("sllv_31", 32'h80000000, 1'b0);
        op(6'b000100, 32'hFFFFFFE0, 32'h12345678); chk("sllv_0_hi_ignored", 32'h12345678, 1'b0);
        op(6'b000111, 32'h0000003F, 32'h80000000); chk("srav_31", 32'hFFFFFFFF, 1'b0);
        op(6'b000110, 32'h0000001F, 32'h80000000); chk("srlv_31", 32'h00000001, 1'b0);
        op(6'b000100, 32'h00000008, 32'h00A5A5A5); chk("sllv_8", 32'hA5A5A500, 1'b0);
        op(6'b001111, 32'h12345678, 32'h0000ABCD); chk("lui", 32'hABCD0000, 1'b0);
        op(6'b100000, 32'h7FFFFFFF, 32'h00000001); chk("add_ovf_again", 32'h80000000, 1'b1);
        op(6'b111111, 32'h7FFFFFFF, 32'h00000001); chk("unlisted", 32'h00000000, 1'b0);
        op(6'b100111, 32'h00000000, 32'h00000000); chk("nor", 32'hFFFFFFFF, 1'b0);
        alucont = 6'b100100;
        a = 32'h0;
        b = 32'h0;
        #2;
        chk("hold_between_edges", 32'hFFFFFFFF, 1'b0);
        reset = 1'b1;
        #1;
        chk("async_reset", 32'h00000000, 1'b0);
        alucont = 6'b100111;
        @(posedge clk);
        #1;
        chk("reset_hold_edge", 32'h00000000, 1'b0);
        #2;
        reset = 1'b0;
        op(6'b100000, 32'h00000002, 32'h00000003); chk("after_release", 32'h00000005, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
